// File: rtl/r8_mul_pkg.sv
// Shared definitions for the radix-8 Booth multiplier: digit encoding,
// group count and window decode.
package r8_mul_pkg;

   typedef enum logic [3:0] {ZERO, P1, P2, P3, P4, N1, N2, N3, N4} booth_digit_t;

   // One group per three multiplier bits of the (WIDTH+2)-bit extended operand.
   function automatic int group_count(input int width);
      return (width + 4) / 3;
   endfunction

   // Window bits are {b[3i+2], b[3i+1], b[3i], b[3i-1]}; weight -4,2,1,1.
   function automatic booth_digit_t decode_digit(input logic [3:0] win);
      booth_digit_t d;
      case (win)
         4'b0001, 4'b0010: d = P1;
         4'b0011, 4'b0100: d = P2;
         4'b0101, 4'b0110: d = P3;
         4'b0111:          d = P4;
         4'b1000:          d = N4;
         4'b1001, 4'b1010: d = N3;
         4'b1011, 4'b1100: d = N2;
         4'b1101, 4'b1110: d = N1;
         default:          d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/r8_booth_pp.sv
// One Booth partial product: selects 0/1/2/3/4 x a_ext, inverts for negative
// digits and reports the +1 correction that completes the negation.
module r8_booth_pp
   import r8_mul_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]         win,
   input  logic [WIDTH+1:0]   a_ext,
   input  logic [WIDTH+3:0]   a3,
   output logic [2*WIDTH-1:0] pp,
   output logic               neg
);
   localparam int MW = WIDTH + 4;
   localparam int PW = 2 * WIDTH;

   booth_digit_t      digit;
   logic [MW-1:0]     a_sx;
   logic [MW-1:0]     mag;
   logic [MW-1:0]     sel;

   assign digit = decode_digit(win);
   assign a_sx  = MW'($signed(a_ext));

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      mag = '0;
      case (digit)
         P1, N1:  mag = a_sx;
         P2, N2:  mag = a_sx << 1;
         P3, N3:  mag = a3;
         P4, N4:  mag = a_sx << 2;
         default: mag = '0;
      endcase
      neg = digit inside {N1, N2, N3, N4};
      sel = neg ? ~mag : mag;
   end

   assign pp = PW'($signed(sel));

endmodule

// File: rtl/r8_booth_mul_pipe.sv
// Three-stage radix-8 Booth multiplier: recode, CSA reduction, final add,
// with valid/ready flow control and a sideband tag.
module r8_booth_mul_pipe
   import r8_mul_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int EW   = WIDTH + 2;
   localparam int MW   = WIDTH + 4;
   localparam int PW   = 2 * WIDTH;
   localparam int G    = group_count(WIDTH);
   localparam int BW   = 3 * G;
   localparam int NOPS = G + 1;

   logic s1_v, s2_v, s3_v;
   logic adv1, adv2, adv3, in_fire;

   assign adv3      = !s3_v || out_ready;
   assign adv2      = !s2_v || adv3;
   assign adv1      = !s1_v || adv2;
   assign in_ready  = rst_n && adv1;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s3_v;

   logic [EW-1:0] a_ext_d, b_ext_d;
   logic [MW-1:0] a3_d;
   logic [BW-1:0] b_win_d;

   assign a_ext_d = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
   assign b_ext_d = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
   assign a3_d    = MW'($signed(a_ext_d)) + MW'($signed({a_ext_d, 1'b0}));
   assign b_win_d = BW'($signed(b_ext_d));

   logic [EW-1:0]    s1_a_ext;
   logic [MW-1:0]    s1_a3;
   logic [BW-1:0]    s1_win;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic [PW-1:0]    s2_sum, s2_carry;

   // The registered multiplier bits are the raw Booth digit windows.
   logic [BW:0]     win_all;
   logic [PW-1:0]   ops [G];
   logic [G-1:0]    neg_vec;
   logic [PW-1:0]   corr;
   logic [PW-1:0]   tree_sum, tree_carry;

   assign win_all = {s1_win, 1'b0};

   for (genvar gi = 0; gi < G; gi++) begin : g_pp
      logic [PW-1:0] pp;
      r8_booth_pp #(.WIDTH(WIDTH)) u_pp (
         .win   (win_all[3*gi+3:3*gi]),
         .a_ext (s1_a_ext),
         .a3    (s1_a3),
         .pp    (pp),
         .neg   (neg_vec[gi])
      );
      assign ops[gi] = pp << (3 * gi);
   end

   always_comb begin
      corr = '0;
      for (int i = 0; i < G; i++) corr[3*i] = neg_vec[i];
   end

   // Operand slots are consumed three at a time in order; compressor k appends
   // its sum and carry as slots NOPS+2k and NOPS+2k+1, giving a log-depth tree.
   for (genvar k = 0; k < NOPS - 2; k++) begin : g_csa
      logic [PW-1:0] x [3];
      logic [PW-1:0] s, c;
      for (genvar t = 0; t < 3; t++) begin : g_in
         localparam int J = 3 * k + t;
         if (J < G) begin : g_pp_in
            assign x[t] = ops[J];
         end else if (J == G) begin : g_corr_in
            assign x[t] = corr;
         end else if ((J - NOPS) % 2 == 0) begin : g_sum_in
            assign x[t] = g_csa[(J - NOPS) / 2].s;
         end else begin : g_carry_in
            assign x[t] = g_csa[(J - NOPS) / 2].c;
         end
      end
      assign s = x[0] ^ x[1] ^ x[2];
      assign c = ((x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2])) << 1;
      if (k == NOPS - 3) begin : g_root
         assign tree_sum   = s;
         assign tree_carry = c;
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else begin
         if (adv1) s1_v <= in_valid;
         if (adv2) s2_v <= s1_v;
         if (adv3) s3_v <= s2_v;
      end
   end

   // NOTE: datapath registers carry no reset; their contents are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_a_ext <= a_ext_d;
         s1_a3    <= a3_d;
         s1_win   <= b_win_d;
         s1_tag   <= in_tag;
      end
      if (adv2 && s1_v) begin
         s2_sum   <= tree_sum;
         s2_carry <= tree_carry;
         s2_tag   <= s1_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         out_tag <= '0;
      end else if (adv3 && s2_v) begin
         result  <= s2_sum + s2_carry;
         out_tag <= s2_tag;
      end
   end

endmodule

// File: tb/tb_r8_booth_mul_pipe.sv
// Self-checking bench for r8_booth_mul_pipe (WIDTH=16): directed corner
// products, stall/ordering, mid-flight reset and randomized traffic.
module tb_r8_booth_mul_pipe;
   localparam int W  = 16;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [W-1:0]  a, b;
   logic [TW-1:0] in_tag, out_tag;
   logic [2*W-1:0] result;

   always #5 clk = ~clk;

   r8_booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [2*W-1:0] res;
      logic [TW-1:0]  tag;
   } exp_t;

   exp_t           q[$];
   int             n_tests = 0;
   int             n_fail  = 0;
   int             cyc     = 0;
   int             last_out_cyc = -1;
   logic [2*W-1:0] last_res;
   bit             accepted;
   bit             held = 1'b0;
   logic [2*W-1:0] held_res;
   logic [TW-1:0]  held_tag;

   // Reference: plain integer product of the operands read in the chosen mode.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
      longint px, py;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      return (2*W)'(px * py);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already driven at the falling edge; observe, then advance.
   task automatic cycle();
      exp_t e;
      #1;
      if (held) begin
         check("stall_hold_valid", 64'(out_valid), 64'd1);
         check("stall_hold_result", 64'(result), 64'(held_res));
         check("stall_hold_tag", 64'(out_tag), 64'(held_tag));
      end
      held     = out_valid && !out_ready;
      held_res = result;
      held_tag = out_tag;
      if (out_valid && out_ready) begin
         last_out_cyc = cyc;
         last_res     = result;
         if (q.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("out_tag", 64'(out_tag), 64'(e.tag));
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) q.push_back('{ref_mul(a, b, is_signed), in_tag});
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [W-1:0]   da [5] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
   logic [W-1:0]   db [5] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h0003};
   logic           ds [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [2*W-1:0] dr [5] = '{32'h40000000, 32'hFFFE0001, 32'h00000001, 32'hFFFFFFFD, 32'h0002FFFD};

   initial begin
      int acc_cyc;
      int n_acc;
      int iter;
      logic [W-1:0] corner [4];
      corner = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
      a = '0; b = '0; in_tag = '0;

      // Reset state
      @(negedge clk); @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed corner products with latency
      for (int i = 0; i < 5; i++) begin
         a = da[i]; b = db[i]; is_signed = ds[i]; in_tag = TW'(i + 1);
         in_valid = 1'b1; out_ready = 1'b1;
         acc_cyc = cyc;
         cycle();
         check($sformatf("dir%0d_accept", i), 64'(accepted), 64'd1);
         in_valid = 1'b0;
         repeat (4) cycle();
         check($sformatf("dir%0d_latency", i), 64'(last_out_cyc - acc_cyc), 64'd3);
         check($sformatf("dir%0d_value", i), 64'(last_res), 64'(dr[i]));
      end

      // Stall: tags 0..9 with out_ready low for the first 5 cycles
      n_acc = 0;
      for (int c = 0; c < 60; c++) begin
         out_ready = (c >= 5);
         in_valid  = (n_acc < 10);
         in_tag    = TW'(n_acc);
         a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
         if (c == 3 || c == 4) begin
            #1;
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("full_accepts", 64'(n_acc), 64'd3);
         end
         cycle();
         if (accepted) n_acc++;
         if (n_acc == 10 && q.size() == 0) break;
      end
      in_valid = 1'b0;
      check("stall_accepted", 64'(n_acc), 64'd10);
      check("stall_drained", 64'(q.size()), 64'd0);

      // Reset with two operations in flight
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = W'($urandom); b = W'($urandom); in_tag = TW'(i + 5);
         cycle();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      q.delete();
      held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midrst_recover_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      last_out_cyc = -1;
      repeat (8) cycle();
      check("midrst_no_stale", 64'(last_out_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

      // Randomized traffic with random back-pressure
      n_acc = 0;
      iter  = 0;
      while (n_acc < 3000 && iter < 20000) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         a = ($urandom % 5 == 0) ? corner[$urandom % 4] : W'($urandom);
         b = ($urandom % 5 == 0) ? corner[$urandom % 4] : W'($urandom);
         is_signed = 1'($urandom);
         in_tag    = TW'($urandom);
         cycle();
         if (accepted) n_acc++;
         iter++;
      end
      check("random_accepts", 64'(n_acc), 64'd3000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
      check("random_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
